// File: rtl/div_arbiter_if.sv
// Request/response and divider-side bus of the shared-divider arbiter.
// slave is the arbiter view; master is the requesters-plus-divider view.
interface div_arbiter_if #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 16
);
  logic [NUM_REQ-1:0]             req_valid_i;
  logic [NUM_REQ-1:0]             req_ready_o;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_numerator_i;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_denominator_i;
  logic [NUM_REQ-1:0]             resp_valid_o;
  logic [RESULT_WIDTH-1:0]        resp_result_o;
  logic                           resp_error_o;
  logic [INPUT_WIDTH-1:0]         div_numerator_o;
  logic [INPUT_WIDTH-1:0]         div_denominator_o;
  logic                           div_valid_o;
  logic [RESULT_WIDTH-1:0]        div_result_i;
  logic                           div_valid_i;

  modport slave (
    input  req_valid_i, req_numerator_i, req_denominator_i, div_result_i, div_valid_i,
    output req_ready_o, resp_valid_o, resp_result_o, resp_error_o,
           div_numerator_o, div_denominator_o, div_valid_o
  );

  modport master (
    output req_valid_i, req_numerator_i, req_denominator_i, div_result_i, div_valid_i,
    input  req_ready_o, resp_valid_o, resp_result_o, resp_error_o,
           div_numerator_o, div_denominator_o, div_valid_o
  );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among NUM_REQ requesters.
// One division in flight; a WAIT-state watchdog turns a lost divider result
// into an error response so the requester is never left hanging.
module div_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 16,
  parameter int RESULT_WIDTH = 16,
  parameter int TIMEOUT      = 2*RESULT_WIDTH
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  div_arbiter_if.slave bus,
  output logic         busy_o
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  state_e                              state_q, state_d;
  logic   [IDW-1:0]                    last_q, id_q, gnt_idx;
  logic                                gnt_any, hs, timeout_hit;
  logic   [CW-1:0]                     cnt_q;
  logic   [NUM_REQ-1:0]                grant, resp_vld_q;
  logic   [NUM_REQ-1:0][INPUT_WIDTH-1:0] num_arr, den_arr;
  logic   [INPUT_WIDTH-1:0]            num_q, den_q;
  logic   [RESULT_WIDTH-1:0]           res_q;
  logic                                err_q, div_vld_q;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
    assign num_arr[k] = bus.req_numerator_i[k*INPUT_WIDTH +: INPUT_WIDTH];
    assign den_arr[k] = bus.req_denominator_i[k*INPUT_WIDTH +: INPUT_WIDTH];
  end

  // Round-robin pick: first valid requester starting just after the last grant.
  always_comb begin
    int k;
    k       = 0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_q) + i) % NUM_REQ;
      if (!gnt_any && bus.req_valid_i[IDW'(k)]) begin
        gnt_any = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
  end

  // Grant is only offered while idle; one-hot on the picked requester.
  always_comb begin
    grant = '0;
    if (state_q == S_IDLE && gnt_any) grant[gnt_idx] = 1'b1;
  end

  assign hs          = |(grant & bus.req_valid_i);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state logic; the result beats the watchdog when both land together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hs) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (bus.div_valid_i || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Operand capture, watchdog counter and response generation.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_q     <= IDW'(NUM_REQ - 1);
      id_q       <= '0;
      cnt_q      <= '0;
      resp_vld_q <= '0;
      res_q      <= '0;
      err_q      <= 1'b0;
      div_vld_q  <= 1'b0;
      num_q      <= '0;
      den_q      <= '0;
    end else begin
      resp_vld_q <= '0;
      div_vld_q  <= hs;
      case (state_q)
        S_IDLE: if (hs) begin
          num_q  <= num_arr[gnt_idx];
          den_q  <= den_arr[gnt_idx];
          id_q   <= gnt_idx;
          last_q <= gnt_idx;
        end
        S_ISSUE: cnt_q <= '0;
        S_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (bus.div_valid_i) begin
            resp_vld_q[id_q] <= 1'b1;
            res_q            <= bus.div_result_i;
            err_q            <= 1'b0;
          end else if (timeout_hit) begin
            resp_vld_q[id_q] <= 1'b1;
            res_q            <= '0;
            err_q            <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o       = grant;
  assign bus.resp_valid_o      = resp_vld_q;
  assign bus.resp_result_o     = res_q;
  assign bus.resp_error_o      = err_q;
  assign bus.div_numerator_o   = num_q;
  assign bus.div_denominator_o = den_q;
  assign bus.div_valid_o       = div_vld_q;
  assign busy_o                = (state_q != S_IDLE);
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model that predicts
// grant order and response timing from cycle arithmetic.
module tb_div_arbiter;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int RW = 16;
  localparam int TO = 32;

  logic clk_i;
  logic reset_ni;
  logic busy_o;

  div_arbiter_if #(.NUM_REQ(N), .INPUT_WIDTH(W), .RESULT_WIDTH(RW)) bus ();

  div_arbiter #(.NUM_REQ(N), .INPUT_WIDTH(W), .RESULT_WIDTH(RW), .TIMEOUT(TO)) dut (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .bus      (bus),
    .busy_o   (busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int total = 0;
  int bad   = 0;

  // requester side
  logic [N-1:0] rv;
  logic [W-1:0] rnum [N];
  logic [W-1:0] rden [N];

  // divider model configuration
  int   div_delay;
  logic div_never;

  // reference model state
  int          cyc, free_at, iss_cyc, last, m_id, h, h2;
  logic        pend, m_e, exp_err;
  logic [W-1:0]  m_num, m_den;
  logic [RW-1:0] m_q, exp_res;
  int          obs_cyc;
  logic [N-1:0] obs_vec;
  int          gq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int lst);
    for (int i = 1; i <= N; i++) begin
      if (v[(lst + i) % N]) return (lst + i) % N;
    end
    return -1;
  endfunction

  // Divider model: quotient returned div_delay cycles after the start pulse,
  // junk on the result bus otherwise; keeps counting through an arbiter reset.
  initial begin
    int cd;
    logic [RW-1:0] q;
    cd = 0;
    q  = '0;
    bus.div_valid_i  = 1'b0;
    bus.div_result_i = '0;
    forever begin
      @(posedge clk_i); #1;
      bus.div_valid_i  = 1'b0;
      bus.div_result_i = RW'($urandom);
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus.div_valid_i  = 1'b1;
          bus.div_result_i = q;
        end
      end
      if (bus.div_valid_o === 1'b1 && !div_never) begin
        cd = div_delay;
        q  = (bus.div_denominator_o == '0) ? '1 :
             RW'(bus.div_numerator_o / bus.div_denominator_o);
      end
    end
  end

  task automatic model_clear();
    pend = 1'b0; free_at = 0; iss_cyc = -1; last = N - 1;
    exp_res = '0; exp_err = 1'b0;
  endtask

  task automatic do_reset();
    rv = '0;
    bus.req_valid_i = '0;
    reset_ni = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(bus.resp_valid_o), 64'(0));
    chk("rst_resp_result", 64'(bus.resp_result_o), 64'(0));
    chk("rst_resp_error", 64'(bus.resp_error_o), 64'(0));
    chk("rst_div_valid", 64'(bus.div_valid_o), 64'(0));
    chk("rst_div_num", 64'(bus.div_numerator_o), 64'(0));
    chk("rst_div_den", 64'(bus.div_denominator_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_ready", 64'(bus.req_ready_o), 64'(0));
    @(posedge clk_i); #4;
    reset_ni = 1'b1;
    model_clear();
  endtask

  // One clock cycle: drive requester inputs, then check every output.
  task automatic step();
    int g;
    logic [N-1:0] er;
    int dly;
    @(posedge clk_i); #2;
    cyc++;
    bus.req_valid_i = rv;
    for (int k = 0; k < N; k++) begin
      bus.req_numerator_i[k*W +: W]   = rnum[k];
      bus.req_denominator_i[k*W +: W] = rden[k];
    end
    #1;
    er = '0;
    if (pend && cyc == free_at) begin
      er[m_id] = 1'b1;
      exp_res  = m_q;
      exp_err  = m_e;
      pend     = 1'b0;
    end
    chk("resp_valid", 64'(bus.resp_valid_o), 64'(er));
    chk("resp_result", 64'(bus.resp_result_o), 64'(exp_res));
    chk("resp_error", 64'(bus.resp_error_o), 64'(exp_err));
    if (bus.resp_valid_o != '0) begin
      obs_cyc = cyc;
      obs_vec = bus.resp_valid_o;
    end
    chk("busy", 64'(busy_o), 64'(cyc < free_at));
    chk("div_valid", 64'(bus.div_valid_o), 64'(cyc == iss_cyc));
    if (pend) begin
      chk("div_num", 64'(bus.div_numerator_o), 64'(m_num));
      chk("div_den", 64'(bus.div_denominator_o), 64'(m_den));
    end
    g  = (cyc >= free_at) ? pick(rv, last) : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("ready", 64'(bus.req_ready_o), 64'(er));
    for (int k = 0; k < N; k++) if (bus.req_ready_o[k] === 1'b1) gq.push_back(k);
    if (g >= 0) begin
      pend    = 1'b1;
      m_id    = g;
      last    = g;
      m_num   = rnum[g];
      m_den   = rden[g];
      iss_cyc = cyc + 1;
      dly     = div_never ? TO + 100 : div_delay;
      m_e     = (dly > TO);
      free_at = cyc + 2 + (m_e ? TO : dly);
      m_q     = m_e ? '0 : ((m_den == '0) ? '1 : RW'(m_num / m_den));
      rv[g]   = 1'b0;
    end
  endtask

  initial begin
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    reset_ni = 1'b1;
    rv = '0;
    for (int k = 0; k < N; k++) begin rnum[k] = '0; rden[k] = W'(1); end
    div_delay = 1; div_never = 1'b0;
    bus.req_valid_i = '0; bus.req_numerator_i = '0; bus.req_denominator_i = '0;
    cyc = 0; obs_cyc = -1; obs_vec = '0; m_id = 0; m_e = 1'b0; m_num = '0; m_den = '0; m_q = '0;
    model_clear();
    #1;
    do_reset();

    // single request: requester 2, 100/7, D=17
    div_delay = 17;
    rnum[2] = W'(100); rden[2] = W'(7); rv[2] = 1'b1;
    step(); h = cyc;
    for (int i = 0; i < 22; i++) step();
    chk("single_latency", 64'(obs_cyc - h), 64'(19));
    chk("single_vec", 64'(obs_vec), 64'(4'b0100));
    chk("single_q", 64'(bus.resp_result_o), 64'(14));

    // zero numerator: requester 1, 0/5, D=1
    div_delay = 1;
    rnum[1] = '0; rden[1] = W'(5); rv[1] = 1'b1;
    step(); h = cyc;
    for (int i = 0; i < 4; i++) step();
    chk("zero_latency", 64'(obs_cyc - h), 64'(3));
    chk("zero_vec", 64'(obs_vec), 64'(4'b0010));
    chk("zero_q", 64'(bus.resp_result_o), 64'(0));

    // fairness: everyone held valid after reset
    do_reset();
    div_delay = 3;
    gq.delete();
    for (int i = 0; i < 30; i++) begin
      for (int k = 0; k < N; k++) if (!rv[k]) begin
        rv[k] = 1'b1; rnum[k] = W'($urandom); rden[k] = W'($urandom_range(1, 300));
      end
      step();
    end
    chk("fair_count", 64'(gq.size() >= 5), 64'(1));
    for (int i = 0; i < 5; i++) chk("fair_order", 64'(gq[i]), 64'(exp_order[i]));
    rv = '0;
    for (int i = 0; i < 8; i++) step();

    // timeout, with requester 0 waiting to be granted in the response cycle
    div_never = 1'b1; div_delay = 5;
    rnum[3] = W'(999); rden[3] = W'(9); rv[3] = 1'b1;
    step(); h = cyc;
    rnum[0] = W'(1000); rden[0] = W'(10); rv[0] = 1'b1;
    step(); step();
    div_never = 1'b0;
    for (int i = 0; i < 34; i++) step();
    chk("timeout_latency", 64'(obs_cyc - h), 64'(34));
    chk("timeout_vec", 64'(obs_vec), 64'(4'b1000));
    chk("timeout_err", 64'(bus.resp_error_o), 64'(1));
    for (int i = 0; i < 10; i++) step();
    chk("b2b_latency", 64'(obs_cyc - (h + 34)), 64'(7));
    chk("b2b_vec", 64'(obs_vec), 64'(4'b0001));
    chk("b2b_q", 64'(bus.resp_result_o), 64'(100));

    // reset during the fifth WAIT cycle; the late divider pulse must be ignored
    div_delay = 17;
    rnum[1] = W'(500); rden[1] = W'(3); rv[1] = 1'b1;
    step(); h = cyc;
    for (int i = 0; i < 6; i++) step();
    do_reset();
    obs_cyc = -1;
    for (int i = 0; i < 25; i++) step();
    chk("late_ignored", 64'(obs_cyc), 64'(-1));
    div_delay = 4;
    gq.delete();
    rnum[0] = W'(77); rden[0] = W'(7); rnum[2] = W'(88); rden[2] = W'(8);
    rv[0] = 1'b1; rv[2] = 1'b1;
    step(); h2 = cyc;
    chk("post_rst_grant", 64'((gq.size() > 0) ? gq[0] : -1), 64'(0));
    for (int i = 0; i < 20; i++) step();

    // random traffic
    for (int it = 0; it < 800; it++) begin
      if (cyc + 1 >= free_at) begin
        div_never = ($urandom_range(0, 11) == 0);
        div_delay = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 2, TO) : $urandom_range(1, 20);
      end
      for (int k = 0; k < N; k++) if (!rv[k] && $urandom_range(0, 3) == 0) begin
        rv[k]   = 1'b1;
        rnum[k] = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        rden[k] = W'($urandom_range(1, 65535));
      end
      step();
    end
    rv = '0;
    for (int i = 0; i < 40; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NUM_REQ, 4: number of requesters, at least 2.
- INPUT_WIDTH, 16: operand width.
- RESULT_WIDTH, 16: quotient width.
- TIMEOUT, 2*RESULT_WIDTH: maximum wait cycles for a divider result.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk_i, in, 1: the single clock.
- reset_ni, in, 1: asynchronous, active-low reset.
- req_valid_i, in, NUM_REQ: per-requester request valid.
- req_ready_o, out, NUM_REQ: per-requester grant/accept.
- req_numerator_i, in, NUM_REQ*INPUT_WIDTH: packed numerators; requester k at slice [k*INPUT_WIDTH +: INPUT_WIDTH].
- req_denominator_i, in, NUM_REQ*INPUT_WIDTH: packed denominators, same slicing.
- resp_valid_o, out, NUM_REQ: one-hot response pulse.
- resp_result_o, out, RESULT_WIDTH: quotient, shared by all requesters.
- resp_error_o, out, 1: timeout flag, qualified by resp_valid_o.
- div_numerator_o, out, INPUT_WIDTH: numerator to the shared divider.
- div_denominator_o, out, INPUT_WIDTH: denominator to the shared divider.
- div_valid_o, out, 1: start pulse to the divider.
- div_result_i, in, RESULT_WIDTH: quotient from the divider.
- div_valid_i, in, 1: divider done pulse.
- busy_o, out, 1: high when state is not IDLE.

Function
REQ-003 The block shall share one iterative positive-integer divider among NUM_REQ requesters, with at most one division outstanding.

REQ-004 The FSM shall have three states:
- IDLE: goes to ISSUE on a handshake.
- ISSUE: lasts exactly one cycle, then goes to WAIT.
- WAIT: goes to IDLE on div_valid_i or on timeout.

REQ-005 In IDLE, req_ready_o shall be combinational and one-hot, or all zero when no req_valid_i bit is set.
- The grant goes to the first set req_valid_i bit, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.

REQ-006 req_ready_o shall be all zero in ISSUE and WAIT.
- A requester shall hold req_valid_i and its operands stable until it is granted.
- A request dropped before grant shall be lost, with no response.

REQ-007 On handshake (req_valid_i[g] and req_ready_o[g] both high) the block shall, at the next edge:
- register slice g of both operand buses into div_numerator_o and div_denominator_o;
- store g as the current id;
- set last_grant to g;
- enter ISSUE.

REQ-008 div_valid_o shall be high exactly during the ISSUE cycle.
- div_numerator_o and div_denominator_o shall hold stable from ISSUE until return to IDLE.

REQ-009 In WAIT, a counter cleared on entry shall increment every cycle.
- On div_valid_i, at the next edge: resp_valid_o[id]=1, resp_result_o=div_result_i, resp_error_o=0, state IDLE.

REQ-010 If the counter reaches TIMEOUT-1 with no div_valid_i, the next edge shall set resp_valid_o[id]=1, resp_result_o=0, resp_error_o=1 and state IDLE.
- If div_valid_i arrives in that same cycle, the result shall win and resp_error_o shall be 0.

REQ-011 resp_valid_o shall be a single-cycle registered pulse with no backpressure.
- resp_result_o and resp_error_o shall hold their values until the next response.

REQ-012 div_valid_i arriving in IDLE or ISSUE shall be ignored, with no response and no state change.

REQ-013 The response cycle shall be IDLE, so a new grant may be issued in the same cycle a response pulse is output.

REQ-014 Latency, handshake cycle = 0, for a divider that returns valid D cycles after its start pulse:
- resp_valid_o shall rise in cycle D+2.
- Typical D = RESULT_WIDTH+1, giving cycle RESULT_WIDTH+3.
- For a zero operand D = 1, giving cycle 3.

Reset
REQ-015 While reset_ni is low, asynchronously, the block shall set:
- state IDLE, last_grant NUM_REQ-1, counter 0;
- resp_valid_o 0, resp_result_o 0, resp_error_o 0;
- div_valid_o 0, div_numerator_o 0, div_denominator_o 0;
- busy_o 0.

REQ-016 Reset asserted mid-operation shall abort the division with no response.
- The first grant after reset shall go to the lowest-index valid requester.

Verification
REQ-017 Single request: requester 2 sends 100/7, divider model with D=17, RESULT_WIDTH=16 -> resp_valid_o=4'b0100 in cycle 19, resp_result_o=14, resp_error_o=0.

REQ-018 Fairness: all four requesters held valid after reset -> grants in order 0,1,2,3,0.
- Each requester receives exactly one response per grant, and each response is routed to the granted index.

REQ-019 Zero operand: requester 1 sends 0/5, D=1 -> resp_valid_o[1] in cycle 3, resp_result_o=0.

REQ-020 Timeout: divider model never returns, TIMEOUT=32 -> resp_valid_o[id] with resp_error_o=1 and resp_result_o=0 after exactly 32 WAIT cycles; the next grant proceeds normally.

REQ-021 Reset in WAIT: reset_ni pulsed low at cycle 5 of WAIT -> all outputs 0 immediately.
- A late div_valid_i after reset release is ignored.
- The next grant goes to requester 0.

REQ-022 Back-to-back: a response pulse and a new handshake occur in the same cycle -> div_valid_o pulses in the following cycle with the new operands.
